// File: rtl/fpna_cfg_deserializer.sv
// FPNA configuration bitstream receiver: synchronises the serial pins, assembles
// MSB-first words and issues one config-store write per completed word.
module fpna_cfg_deserializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ena,
  input  logic              i_cfg_sclk,
  input  logic              i_cfg_sdata,
  input  logic              i_cfg_load,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WORD_W-1:0] o_wr_data,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_err_trunc
);

  localparam int unsigned       CNT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_SHIFT, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic                r_sdata_s1, r_sdata_s2, r_sdata_s3;
  logic                r_load_s1, r_load_s2, r_load_s3;
  logic                r_sclk_rise, r_load_fall;
  logic [WORD_W-1:0]   r_shreg;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_take_bit, w_write, w_trunc, w_clear;
  logic [WORD_W-1:0]   w_word;

  assign w_word = {r_shreg[WORD_W-2:0], r_sdata_s3};

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next state and datapath controls; everything holds while ena is low
  always_comb begin
    w_next_state = r_state;
    w_take_bit   = 1'b0;
    w_write      = 1'b0;
    w_trunc      = 1'b0;
    w_clear      = 1'b0;
    if (i_ena) begin
      case (r_state)
        S_IDLE: if (r_load_s3) w_next_state = S_ARM;
        S_ARM: begin
          w_clear = 1'b1;
          if (r_load_fall) w_next_state = S_SHIFT;
        end
        S_SHIFT: begin
          if (r_sclk_rise) begin
            w_take_bit = 1'b1;
            w_write    = (r_bitcnt == LAST_BIT);
          end
          if (r_load_s3) begin
            w_next_state = S_ARM;
            // A word completing on the same cycle as the abort still gets written
            if (!w_write) begin
              w_take_bit = 1'b0;
              w_clear    = 1'b1;
              w_trunc    = (r_bitcnt != '0);
            end
          end else if (w_write && (r_addr == LAST_ADDR)) begin
            w_next_state = S_DONE;
          end
        end
        S_DONE: if (r_load_s3) w_next_state = S_ARM;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Pin synchronisers, edge detection, shift datapath and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sclk_s1    <= 1'b0;
      r_sclk_s2    <= 1'b0;
      r_sclk_s3    <= 1'b0;
      r_sdata_s1   <= 1'b0;
      r_sdata_s2   <= 1'b0;
      r_sdata_s3   <= 1'b0;
      r_load_s1    <= 1'b0;
      r_load_s2    <= 1'b0;
      r_load_s3    <= 1'b0;
      r_sclk_rise  <= 1'b0;
      r_load_fall  <= 1'b0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_addr       <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_err_trunc  <= 1'b0;
    end else begin
      r_sclk_s1   <= i_cfg_sclk;
      r_sclk_s2   <= r_sclk_s1;
      r_sclk_s3   <= r_sclk_s2;
      r_sdata_s1  <= i_cfg_sdata;
      r_sdata_s2  <= r_sdata_s1;
      r_sdata_s3  <= r_sdata_s2;
      r_load_s1   <= i_cfg_load;
      r_load_s2   <= r_load_s1;
      r_load_s3   <= r_load_s2;
      r_sclk_rise <= r_sclk_s2 & ~r_sclk_s3;
      r_load_fall <= ~r_load_s2 & r_load_s3;

      o_wr_en      <= w_write;
      o_frame_done <= w_write && (r_addr == LAST_ADDR);
      o_err_trunc  <= w_trunc;
      o_busy       <= (w_next_state == S_SHIFT);

      if (w_clear) begin
        r_shreg  <= '0;
        r_bitcnt <= '0;
        r_addr   <= '0;
      end else if (w_take_bit) begin
        r_shreg <= w_word;
        if (w_write) begin
          r_bitcnt <= '0;
          r_addr   <= r_addr + ADDR_W'(1);
        end else begin
          r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
      end

      if (w_write) begin
        o_wr_addr <= r_addr;
        o_wr_data <= w_word;
      end
    end
  end

endmodule

// File: tb/tb_fpna_cfg_deserializer.sv
// Scoreboard bench for fpna_cfg_deserializer: a bit-level model predicts each
// config write (address, data, frame_done, arrival cycle) as the pins are driven.
module tb_fpna_cfg_deserializer;

  typedef struct {
    logic [3:0]  addr;
    logic [7:0]  data;
    logic        last;
    int unsigned cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       cfg_sclk, cfg_sdata, cfg_load;
  logic       wr_en, busy, frame_done, err_trunc;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  int unsigned n_wr     = 0;
  int unsigned obs_trunc = 0;
  int unsigned exp_trunc = 0;
  exp_t        sb_q[$];

  // Bench model of the receiver
  bit          mdl_active = 1'b0;
  int unsigned mdl_cnt    = 0;
  logic [7:0]  mdl_sh     = '0;
  logic [3:0]  mdl_addr   = '0;

  fpna_cfg_deserializer #(.WORD_W(8), .DEPTH(16), .ADDR_W(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ena        (ena),
    .i_cfg_sclk   (cfg_sclk),
    .i_cfg_sdata  (cfg_sdata),
    .i_cfg_load   (cfg_load),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_frame_done (frame_done),
    .o_err_trunc  (err_trunc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor: sampled 1 time unit after each active edge
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    if (wr_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_wr_en", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("frame_done", frame_done, e.last);
        chk("wr_latency", cyc, e.cyc);
      end
      n_wr++;
    end else if (frame_done === 1'b1) begin
      chk("frame_done_without_wr", 1, 0);
    end
    if (err_trunc === 1'b1) obs_trunc++;
  end

  // One sclk period (4 clk low, 4 clk high) carrying bit b
  task automatic send_bit(input logic b);
    exp_t e;
    cfg_sclk  = 1'b0;
    cfg_sdata = b;
    repeat (4) @(negedge clk);
    cfg_sclk = 1'b1;
    if (mdl_active && ena) begin
      mdl_sh = {mdl_sh[6:0], b};
      mdl_cnt++;
      if (mdl_cnt == 8) begin
        e.addr = mdl_addr;
        e.data = mdl_sh;
        e.last = (mdl_addr == 4'd15);
        e.cyc  = cyc + 4;
        sb_q.push_back(e);
        mdl_cnt = 0;
        if (mdl_addr == 4'd15) mdl_active = 1'b0;
        mdl_addr = mdl_addr + 4'd1;
      end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int k = 7; k >= 0; k--) send_bit(w[k]);
  endtask

  // Load pulse: arms the receiver, falling edge opens a new frame
  task automatic frame_start();
    cfg_sclk = 1'b0;
    cfg_load = 1'b1;
    if (mdl_active && mdl_cnt != 0) exp_trunc++;
    mdl_active = 1'b0;
    repeat (6) @(negedge clk);
    cfg_load = 1'b0;
    mdl_active = 1'b1;
    mdl_cnt    = 0;
    mdl_sh     = '0;
    mdl_addr   = '0;
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_trunc"}, err_trunc, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [9:0] ena_bits;
    rst_n     = 1'b0;
    ena       = 1'b1;
    cfg_sclk  = 1'b0;
    cfg_sdata = 1'b0;
    cfg_load  = 1'b0;

    // Reset with pins toggling
    repeat (2) begin
      @(negedge clk);
      cfg_sclk  = 1'($urandom_range(0, 1));
      cfg_sdata = 1'($urandom_range(0, 1));
      cfg_load  = 1'($urandom_range(0, 1));
    end
    chk_outputs_zero("rst");
    @(negedge clk);
    cfg_sclk = 1'b0; cfg_sdata = 1'b0; cfg_load = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_wr_after_rst", n_wr, 0);
    chk("idle_busy", busy, 0);

    // Single word 0xA5
    frame_start();
    chk("busy_in_shift", busy, 1);
    send_word(8'hA5);
    repeat (4) @(negedge clk);
    chk("wr_count_single", n_wr, 1);
    chk("wr_data_hold", wr_data, 8'hA5);
    chk("wr_addr_hold", wr_addr, 0);

    // Full frame, then ignored trailing bits
    frame_start();
    for (int i = 0; i < 16; i++) send_word(8'(i));
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    chk("busy_after_frame", busy, 0);
    chk("wr_count_frame", n_wr, 17);
    chk("last_addr", wr_addr, 4'd15);

    // Truncated frame then a fresh word
    frame_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    frame_start();
    chk("trunc_pulses", obs_trunc, exp_trunc);
    chk("trunc_one_pulse", obs_trunc, 1);
    chk("no_wr_on_trunc", n_wr, 17);
    send_word(8'h3C);
    repeat (4) @(negedge clk);
    chk("wr_after_trunc_addr", wr_addr, 0);

    // ena dropped for two sclk rises of word 0x81; two more bits finish it
    frame_start();
    ena_bits = 10'b10_0000_0111;
    for (int i = 0; i < 10; i++) begin
      ena = !(i == 4 || i == 5);
      send_bit(ena_bits[9-i]);
    end
    ena = 1'b1;
    repeat (4) @(negedge clk);
    chk("ena_word_data", wr_data, 8'h87);
    chk("wr_count_ena", n_wr, 19);

    // Reset mid-frame after word 5
    frame_start();
    for (int i = 0; i < 6; i++) send_word(8'(8'h10 + i));
    @(negedge clk);
    rst_n = 1'b0;
    mdl_active = 1'b0;
    repeat (2) @(negedge clk);
    chk_outputs_zero("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
    chk("idle_after_midrst", busy, 0);
    chk("no_wr_after_midrst", n_wr, 25);
    frame_start();
    send_word(8'h5A);
    repeat (6) @(negedge clk);
    chk("restart_addr", wr_addr, 0);
    chk("restart_data", wr_data, 8'h5A);

    chk("scoreboard_empty", sb_q.size(), 0);
    chk("trunc_total", obs_trunc, exp_trunc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
